// File: rtl/usbfs_pkg.sv
// Shared constants for the USB-FS core blocks.
package usbfs_pkg;
    localparam int IN_FIFO_DEPTH_LOG2_DEFAULT = 10;
    localparam int OVF_CNT_W                  = 16;
    localparam int BYTE_W                     = 8;
endpackage

// File: rtl/usbfs_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module usbfs_sdp_ram
    import usbfs_pkg::*;
#(
    parameter int AW = IN_FIFO_DEPTH_LOG2_DEFAULT,
    parameter int DW = BYTE_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2**AW];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/usbfs_in_fifo.sv
// Byte FIFO feeding the device-to-host endpoint stream; RAM plus a registered output stage.
module usbfs_in_fifo
    import usbfs_pkg::*;
#(
    parameter int DEPTH_LOG2  = IN_FIFO_DEPTH_LOG2_DEFAULT,
    parameter int AFULL_LEVEL = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  wr_afull,
    output logic                  wr_drop,
    output logic [OVF_CNT_W-1:0]  ovf_cnt,
    output logic [DEPTH_LOG2:0]   level,
    output logic [BYTE_W-1:0]     in_data,
    output logic                  in_valid,
    input  logic                  in_ready
);
    localparam int              LW        = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]   CAPACITY  = LW'(2 ** DEPTH_LOG2);
    localparam logic [LW-1:0]   AFULL_THR = LW'(AFULL_LEVEL);

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  fetch_pending;
    logic [BYTE_W-1:0]     ram_q;
    logic                  wr_accept;
    logic                  handshake;
    logic                  fetch;
    logic [LW-1:0]         ram_entries;
    logic [LW-1:0]         level_next;

    // in_valid/in_ready: a byte moves when both are high at a clock edge; while in_valid
    // is high and in_ready low, in_data and in_valid hold their values.
    always_comb begin
        wr_accept   = wr_en & ~wr_full & ~flush;
        handshake   = in_valid & in_ready;
        ram_entries = level - LW'(fetch_pending) - LW'(in_valid);
        fetch       = ~flush & (ram_entries != '0) & ~fetch_pending & (~in_valid | in_ready);
        level_next  = level;
        if (wr_accept & ~handshake)      level_next = level + LW'(1);
        else if (~wr_accept & handshake) level_next = level - LW'(1);
    end

    usbfs_sdp_ram #(
        .AW (DEPTH_LOG2),
        .DW (BYTE_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wptr),
        .wr_data (wr_data),
        .rd_en   (fetch),
        .rd_addr (rptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            fetch_pending <= 1'b0;
            in_valid      <= 1'b0;
            in_data       <= '0;
            level         <= '0;
            wr_full       <= 1'b0;
            wr_afull      <= 1'b0;
            wr_drop       <= 1'b0;
            ovf_cnt       <= '0;
        end else if (flush) begin
            wptr          <= '0;
            rptr          <= '0;
            fetch_pending <= 1'b0;
            in_valid      <= 1'b0;
            in_data       <= '0;
            level         <= '0;
            wr_full       <= 1'b0;
            wr_afull      <= 1'b0;
            wr_drop       <= 1'b0;
        end else begin
            if (wr_accept) wptr <= wptr + DEPTH_LOG2'(1);
            if (fetch)     rptr <= rptr + DEPTH_LOG2'(1);
            fetch_pending <= fetch;
            // A fetch is only issued when the output stage will be free, so a load never collides.
            if (fetch_pending) begin
                in_data  <= ram_q;
                in_valid <= 1'b1;
            end else if (handshake) begin
                in_valid <= 1'b0;
            end
            level    <= level_next;
            wr_full  <= (level_next == CAPACITY);
            wr_afull <= (level_next >= AFULL_THR);
            wr_drop  <= wr_en & wr_full;
            if (wr_en & wr_full & (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
        end
    end
endmodule
